// File: rtl/cmos_cap_pkg.sv
// Shared constants for the CMOS DVP capture front end.
package cmos_cap_pkg;

   // Capture FSM encoding.
   localparam logic [1:0] ST_SETTLE  = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   // Legal range of input words per pixel and the default settle count.
   localparam int unsigned BPP_MIN        = 1;
   localparam int unsigned BPP_MAX        = 4;
   localparam int unsigned WAIT_FRAME_DEF = 10;

   // Width of the optional per-frame statistics counters.
   localparam int unsigned STAT_W = 16;

   // Saturating increment for the statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Camera-side inputs and frame-buffer-side outputs of cmos_capture_ctrl.
// Optional statistics ports appear when CMOS_CAPTURE_STATS_EN is defined.
interface cmos_capture_ctrl_if #(
   parameter int unsigned IN_W          = 8,
   parameter int unsigned BYTES_PER_PIX = 2,
   parameter int unsigned FCNT_W        = 16
);
   logic                          cam_vsync;
   logic                          cam_href;
   logic [IN_W-1:0]               cam_data;
   logic                          cap_en;
   logic                          single_shot;
   logic                          frame_val_flag;
   logic                          cmos_frame_vsync;
   logic                          cmos_frame_href;
   logic                          cmos_frame_valid;
   logic [IN_W*BYTES_PER_PIX-1:0] cmos_frame_data;
   logic                          frame_done;
   logic [FCNT_W-1:0]             frame_cnt;
`ifdef CMOS_CAPTURE_STATS_EN
   logic [15:0]                   last_line_cnt;
   logic [15:0]                   last_pix_cnt;

   modport master (
      output cam_vsync, cam_href, cam_data, cap_en, single_shot,
      input  frame_val_flag, cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
             cmos_frame_data, frame_done, frame_cnt, last_line_cnt, last_pix_cnt
   );
   modport slave (
      input  cam_vsync, cam_href, cam_data, cap_en, single_shot,
      output frame_val_flag, cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
             cmos_frame_data, frame_done, frame_cnt, last_line_cnt, last_pix_cnt
   );
`else
   modport master (
      output cam_vsync, cam_href, cam_data, cap_en, single_shot,
      input  frame_val_flag, cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
             cmos_frame_data, frame_done, frame_cnt
   );
   modport slave (
      input  cam_vsync, cam_href, cam_data, cap_en, single_shot,
      output frame_val_flag, cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
             cmos_frame_data, frame_done, frame_cnt
   );
`endif
endinterface

// File: rtl/cmos_pix_pack.sv
// Packs BYTES_PER_PIX camera words into one pixel, most-significant first.
// 'gate' is the capture flag as it will be in the output cycle, so the
// registered strobe/data are already gated when they leave this block.
module cmos_pix_pack #(
   parameter int unsigned IN_W          = 8,
   parameter int unsigned BYTES_PER_PIX = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          href,
   input  logic [IN_W-1:0]               data,
   input  logic                          gate,
   output logic                          valid,
   output logic [IN_W*BYTES_PER_PIX-1:0] pix_data
);
   localparam int unsigned PIX_W = IN_W * BYTES_PER_PIX;
   localparam int unsigned CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_PIX - 1);

   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [PIX_W-1:0] shift_q, shift_d;
   logic [PIX_W-1:0] pix_q,   pix_d;
   logic [PIX_W-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic             strobe;

   // Byte counter and shift register; a partial pixel is dropped when href falls.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pix_d   = pix_q;
      strobe  = 1'b0;
      if (href) begin
         shift_d = PIX_W'({shift_q, data});
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            strobe = 1'b1;
            pix_d  = shift_d;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
      valid_d = strobe & gate;
      data_d  = gate ? pix_d : '0;
   end

   // Packing state and gated output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         pix_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pix_q   <= pix_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign valid    = valid_q;
   assign pix_data = data_q;

endmodule

// File: rtl/cmos_capture_ctrl.sv
// CMOS DVP capture front end: vsync/href sync, settle/run/single-shot FSM
// gated at frame boundaries, pixel packing and a completed-frame counter.
// Define CMOS_CAPTURE_STATS_EN to add last_line_cnt/last_pix_cnt outputs.
module cmos_capture_ctrl
   import cmos_cap_pkg::*;
#(
   parameter int unsigned IN_W          = 8,
   parameter int unsigned BYTES_PER_PIX = 2,
   parameter int unsigned WAIT_FRAME    = WAIT_FRAME_DEF,
   parameter int unsigned FCNT_W        = 16
) (
   input  logic               cam_pclk,
   input  logic               rst_n,
   cmos_capture_ctrl_if.slave bus
);
   localparam int unsigned PIX_W = IN_W * BYTES_PER_PIX;
   localparam logic [7:0]  WAIT_LAST = 8'(WAIT_FRAME - 1);

   logic              vsync_d0_q, vsync_d1_q;
   logic              href_d0_q,  href_d1_q;
   logic [1:0]        state_q,    state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              ss_q,       ss_d;
   logic              flag_q,     flag_d;
   logic              done_q,     done_d;
   logic [FCNT_W-1:0] fcnt_q,     fcnt_d;
   logic              vs_out_q,   vs_out_d;
   logic              hs_out_q,   hs_out_d;
   logic              fs;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;

   assign fs = vsync_d0_q & ~vsync_d1_q;

   // Two-flop sampling of the camera sync lines.
   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d0_q <= 1'b0;
         vsync_d1_q <= 1'b0;
         href_d0_q  <= 1'b0;
         href_d1_q  <= 1'b0;
      end else begin
         vsync_d0_q <= bus.cam_vsync;
         vsync_d1_q <= vsync_d0_q;
         href_d0_q  <= bus.cam_href;
         href_d1_q  <= href_d0_q;
      end
   end

   // Next-state logic; every decision is taken only on a frame-start event.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      ss_d       = ss_q;
      done_d     = 1'b0;
      fcnt_d     = fcnt_q;
      case (state_q)
         ST_SETTLE: begin
            if (fs) begin
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d    = ST_IDLE;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'(1);
               end
            end
         end
         ST_IDLE: begin
            if (fs && bus.cap_en) begin
               state_d = ST_CAPTURE;
               ss_d    = bus.single_shot;
            end
         end
         ST_CAPTURE: begin
            if (fs) begin
               done_d = 1'b1;
               fcnt_d = fcnt_q + FCNT_W'(1);
               if (!(bus.cap_en && !ss_q)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_SETTLE;
      endcase
      flag_d   = (state_d == ST_CAPTURE);
      vs_out_d = flag_d & vsync_d0_q;
      hs_out_d = flag_d & href_d0_q;
   end

   // FSM, counters and registered frame-level outputs.
   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SETTLE;
         wait_cnt_q <= '0;
         ss_q       <= 1'b0;
         flag_q     <= 1'b0;
         done_q     <= 1'b0;
         fcnt_q     <= '0;
         vs_out_q   <= 1'b0;
         hs_out_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         ss_q       <= ss_d;
         flag_q     <= flag_d;
         done_q     <= done_d;
         fcnt_q     <= fcnt_d;
         vs_out_q   <= vs_out_d;
         hs_out_q   <= hs_out_d;
      end
   end

   cmos_pix_pack #(
      .IN_W          (IN_W),
      .BYTES_PER_PIX (BYTES_PER_PIX)
   ) u_pack (
      .clk      (cam_pclk),
      .rst_n    (rst_n),
      .href     (bus.cam_href),
      .data     (bus.cam_data),
      .gate     (flag_d),
      .valid    (pix_valid),
      .pix_data (pix_data)
   );

   assign bus.frame_val_flag   = flag_q;
   assign bus.cmos_frame_vsync = vs_out_q;
   assign bus.cmos_frame_href  = hs_out_q;
   assign bus.cmos_frame_valid = pix_valid;
   assign bus.cmos_frame_data  = pix_data;
   assign bus.frame_done       = done_q;
   assign bus.frame_cnt        = fcnt_q;

`ifdef CMOS_CAPTURE_STATS_EN
   logic [STAT_W-1:0] line_cnt_q,  line_cnt_d;
   logic [STAT_W-1:0] pix_cnt_q,   pix_cnt_d;
   logic [STAT_W-1:0] last_line_q, last_line_d;
   logic [STAT_W-1:0] last_pix_q,  last_pix_d;
   logic              href_rise;

   // Raw href edge so the per-line pixel count restarts before the first strobe.
   assign href_rise = bus.cam_href & ~href_d0_q;

   // Line/pixel counting in CAPTURE; snapshot taken on the frame-ending fs.
   always_comb begin
      line_cnt_d  = line_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      last_line_d = last_line_q;
      last_pix_d  = last_pix_q;
      if (state_q == ST_CAPTURE) begin
         if (href_rise) begin
            line_cnt_d = sat_inc(line_cnt_q, 1'b1);
            pix_cnt_d  = '0;
         end else begin
            pix_cnt_d = sat_inc(pix_cnt_q, pix_valid);
         end
      end
      if (fs) begin
         if (state_q == ST_CAPTURE) begin
            last_line_d = line_cnt_q;
            last_pix_d  = sat_inc(pix_cnt_q, pix_valid);
         end
         line_cnt_d = '0;
         pix_cnt_d  = '0;
      end
   end

   // Statistics registers.
   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         last_line_q <= '0;
         last_pix_q  <= '0;
      end else begin
         line_cnt_q  <= line_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         last_line_q <= last_line_d;
         last_pix_q  <= last_pix_d;
      end
   end

   assign bus.last_line_cnt = last_line_q;
   assign bus.last_pix_cnt  = last_pix_q;
`endif

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed bench for cmos_capture_ctrl: two instances (2 and 3 bytes per pixel,
// the second with a 2-bit frame counter) driven from one shared camera stream.
module tb_cmos_capture_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       vs, hs, cap, ss;
   logic [7:0] d;

   int checks = 0;
   int errors = 0;
   int nval2, nval3, ndone2, nflag2;

   always #5 clk = ~clk;

   cmos_capture_ctrl_if #(.IN_W(8), .BYTES_PER_PIX(2), .FCNT_W(16)) bus2 ();
   cmos_capture_ctrl_if #(.IN_W(8), .BYTES_PER_PIX(3), .FCNT_W(2))  bus3 ();

   assign bus2.cam_vsync = vs;  assign bus2.cam_href = hs;  assign bus2.cam_data = d;
   assign bus2.cap_en = cap;    assign bus2.single_shot = ss;
   assign bus3.cam_vsync = vs;  assign bus3.cam_href = hs;  assign bus3.cam_data = d;
   assign bus3.cap_en = cap;    assign bus3.single_shot = ss;

   cmos_capture_ctrl #(.IN_W(8), .BYTES_PER_PIX(2), .WAIT_FRAME(3), .FCNT_W(16)) u_dut2 (
      .cam_pclk (clk), .rst_n (rst_n), .bus (bus2.slave));
   cmos_capture_ctrl #(.IN_W(8), .BYTES_PER_PIX(3), .WAIT_FRAME(3), .FCNT_W(2)) u_dut3 (
      .cam_pclk (clk), .rst_n (rst_n), .bus (bus3.slave));

   // One clock: apply inputs, pass the edge, tally strobes 1 time unit later.
   task automatic cyc(input logic v, input logic h, input logic [7:0] dd);
      vs = v; hs = h; d = dd;
      @(posedge clk); #1;
      nval2  += int'(bus2.cmos_frame_valid);
      nval3  += int'(bus3.cmos_frame_valid);
      ndone2 += int'(bus2.frame_done);
      nflag2 += int'(bus2.frame_val_flag);
   endtask

   task automatic clr();
      nval2 = 0; nval3 = 0; ndone2 = 0; nflag2 = 0;
   endtask

   task automatic vs_start();
      cyc(1'b1, 1'b0, 8'h00); cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic line(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, base + 8'(i));
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vs = 1'b0; hs = 1'b0; d = 8'h00; cap = 1'b0; ss = 1'b0;
      clr();
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", bus2.frame_val_flag); end
      checks++; if (bus2.cmos_frame_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", bus2.cmos_frame_vsync); end
      checks++; if (bus2.cmos_frame_href !== 1'b0) begin errors++; $display("FAIL reset_href: got %b want 0", bus2.cmos_frame_href); end
      checks++; if (bus2.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus2.cmos_frame_data); end
      checks++; if (bus2.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus2.frame_done); end
      checks++; if (bus2.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus2.frame_cnt); end
      checks++; if (bus3.cmos_frame_data !== 24'h0) begin errors++; $display("FAIL reset_data3: got %h want 000000", bus3.cmos_frame_data); end
      rst_n = 1'b1;
   endtask

   // Three frames are discarded, the fourth frame start enters CAPTURE.
   task automatic test_settle();
      cap = 1'b1; ss = 1'b0;
      clr();
      repeat (3) begin vs_start(); line(4, 8'h40); end
      checks++; if (nflag2 + nval2 + nval3 !== 0) begin errors++; $display("FAIL settle_activity: got %0d want 0", nflag2 + nval2 + nval3); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL enter_fs_cycle_flag: got %b want 0", bus2.frame_val_flag); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL enter_flag: got %b want 1", bus2.frame_val_flag); end
      checks++; if (bus2.cmos_frame_vsync !== 1'b1) begin errors++; $display("FAIL enter_vsync_out: got %b want 1", bus2.cmos_frame_vsync); end
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
   endtask

   // Bytes 12 34 56 78: 2-byte pixels 1234/5678, 3-byte pixel 123456.
   task automatic test_pack2();
      cyc(1'b0, 1'b1, 8'h12);
      checks++; if (bus2.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL pack2_b1_valid: got %b want 0", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_href !== 1'b0) begin errors++; $display("FAIL pack2_href_lat1: got %b want 0", bus2.cmos_frame_href); end
      cyc(1'b0, 1'b1, 8'h34);
      checks++; if (bus2.cmos_frame_valid !== 1'b1) begin errors++; $display("FAIL pack2_p1_valid: got %b want 1", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_data !== 16'h1234) begin errors++; $display("FAIL pack2_p1_data: got %h want 1234", bus2.cmos_frame_data); end
      checks++; if (bus2.cmos_frame_href !== 1'b1) begin errors++; $display("FAIL pack2_href_lat2: got %b want 1", bus2.cmos_frame_href); end
      cyc(1'b0, 1'b1, 8'h56);
      checks++; if (bus2.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL pack2_gap_valid: got %b want 0", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_data !== 16'h1234) begin errors++; $display("FAIL pack2_hold: got %h want 1234", bus2.cmos_frame_data); end
      checks++; if (bus3.cmos_frame_valid !== 1'b1) begin errors++; $display("FAIL pack3_p1_valid: got %b want 1", bus3.cmos_frame_valid); end
      checks++; if (bus3.cmos_frame_data !== 24'h123456) begin errors++; $display("FAIL pack3_p1_data: got %h want 123456", bus3.cmos_frame_data); end
      cyc(1'b0, 1'b1, 8'h78);
      checks++; if (bus2.cmos_frame_valid !== 1'b1) begin errors++; $display("FAIL pack2_p2_valid: got %b want 1", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_data !== 16'h5678) begin errors++; $display("FAIL pack2_p2_data: got %h want 5678", bus2.cmos_frame_data); end
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
   endtask

   // 7-byte line: trailing partial pixel dropped; the next line starts aligned.
   task automatic test_partial();
      clr();
      line(7, 8'h01);
      checks++; if (nval3 !== 2) begin errors++; $display("FAIL part3_strobes: got %0d want 2", nval3); end
      checks++; if (bus3.cmos_frame_data !== 24'h040506) begin errors++; $display("FAIL part3_data: got %h want 040506", bus3.cmos_frame_data); end
      checks++; if (nval2 !== 3) begin errors++; $display("FAIL part2_strobes: got %0d want 3", nval2); end
      checks++; if (bus2.cmos_frame_data !== 16'h0506) begin errors++; $display("FAIL part2_data: got %h want 0506", bus2.cmos_frame_data); end
      clr();
      line(3, 8'h0A);
      checks++; if (nval3 !== 1) begin errors++; $display("FAIL align3_strobes: got %0d want 1", nval3); end
      checks++; if (bus3.cmos_frame_data !== 24'h0A0B0C) begin errors++; $display("FAIL align3_data: got %h want 0a0b0c", bus3.cmos_frame_data); end
      checks++; if (bus2.cmos_frame_data !== 16'h0A0B) begin errors++; $display("FAIL align2_data: got %h want 0a0b", bus2.cmos_frame_data); end
   endtask

   // Continuous mode: frame_done on the boundary, flag never drops.
   task automatic test_continuous();
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL cont_flag_fs: got %b want 1", bus2.frame_val_flag); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL cont_flag_after: got %b want 1", bus2.frame_val_flag); end
      checks++; if (bus2.frame_done !== 1'b1) begin errors++; $display("FAIL cont_done: got %b want 1", bus2.frame_done); end
      checks++; if (bus2.frame_cnt !== 16'd1) begin errors++; $display("FAIL cont_cnt: got %0d want 1", bus2.frame_cnt); end
      cyc(1'b0, 1'b0, 8'h00);
      checks++; if (bus2.frame_done !== 1'b0) begin errors++; $display("FAIL cont_done_pulse: got %b want 0", bus2.frame_done); end
      cyc(1'b0, 1'b0, 8'h00);
   endtask

   // cap_en dropped mid-frame: frame completes, later frames ignored.
   task automatic test_cap_drop();
      clr();
      line(4, 8'h20);
      cap = 1'b0;
      line(4, 8'h30);
      checks++; if (nval2 !== 4) begin errors++; $display("FAIL drop_full_frame: got %0d want 4", nval2); end
      checks++; if (bus2.cmos_frame_data !== 16'h3233) begin errors++; $display("FAIL drop_last_data: got %h want 3233", bus2.cmos_frame_data); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL drop_flag_fs: got %b want 1", bus2.frame_val_flag); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL drop_flag_exit: got %b want 0", bus2.frame_val_flag); end
      checks++; if (bus2.frame_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d want 2", bus2.frame_cnt); end
      checks++; if (bus2.cmos_frame_data !== 16'h0000) begin errors++; $display("FAIL drop_data_zero: got %h want 0000", bus2.cmos_frame_data); end
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
      clr();
      line(4, 8'h50);
      vs_start();
      line(4, 8'h58);
      checks++; if (nval2 + nflag2 + ndone2 !== 0) begin errors++; $display("FAIL drop_idle_activity: got %0d want 0", nval2 + nflag2 + ndone2); end
   endtask

   // Single shot with cap_en held: one frame per arm, exit fs does not re-arm.
   task automatic test_single_shot();
      cap = 1'b1; ss = 1'b1;
      vs_start();
      clr();
      cyc(1'b0, 1'b1, 8'hAB); cyc(1'b0, 1'b1, 8'hCD);
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
      checks++; if (nval2 !== 1 || bus2.cmos_frame_data !== 16'hABCD) begin errors++; $display("FAIL ss_pixel: got %0d/%h want 1/abcd", nval2, bus2.cmos_frame_data); end
      cyc(1'b0, 1'b1, 8'h11);
      cyc(1'b1, 1'b1, 8'h22);
      checks++; if (bus2.cmos_frame_valid !== 1'b1) begin errors++; $display("FAIL ss_fs_strobe_valid: got %b want 1", bus2.cmos_frame_valid); end
      checks++; if (bus2.cmos_frame_data !== 16'h1122) begin errors++; $display("FAIL ss_fs_strobe_data: got %h want 1122", bus2.cmos_frame_data); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL ss_exit_flag: got %b want 0", bus2.frame_val_flag); end
      checks++; if (bus2.frame_cnt !== 16'd3) begin errors++; $display("FAIL ss_cnt: got %0d want 3", bus2.frame_cnt); end
      checks++; if (bus3.frame_cnt !== 2'd3) begin errors++; $display("FAIL ss_cnt3: got %0d want 3", bus3.frame_cnt); end
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
      line(4, 8'h60);
      checks++; if (ndone2 !== 1) begin errors++; $display("FAIL ss_done_once: got %0d want 1", ndone2); end
      checks++; if (nval2 !== 2) begin errors++; $display("FAIL ss_next_frame_idle: got %0d want 2", nval2); end
      vs_start();
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL ss_rearm: got %b want 1", bus2.frame_val_flag); end
      line(4, 8'h70);
      clr();
      vs_start();
      checks++; if (ndone2 !== 1) begin errors++; $display("FAIL ss2_done: got %0d want 1", ndone2); end
      checks++; if (bus2.frame_cnt !== 16'd4) begin errors++; $display("FAIL ss2_cnt: got %0d want 4", bus2.frame_cnt); end
      checks++; if (bus3.frame_cnt !== 2'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", bus3.frame_cnt); end
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL ss2_idle: got %b want 0", bus2.frame_val_flag); end
   endtask

   // Reset mid-line in CAPTURE: immediate clear, settle count restarts.
   task automatic test_reset_mid();
      ss = 1'b0;
      vs_start();
      cyc(1'b0, 1'b1, 8'h99); cyc(1'b0, 1'b1, 8'h88); cyc(1'b0, 1'b1, 8'h77);
      checks++; if (bus2.frame_val_flag !== 1'b1 || bus2.cmos_frame_data !== 16'h9988) begin errors++; $display("FAIL pre_rst: got %b/%h want 1/9988", bus2.frame_val_flag, bus2.cmos_frame_data); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL rst_mid_flag: got %b want 0", bus2.frame_val_flag); end
      checks++; if (bus2.cmos_frame_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h want 0000", bus2.cmos_frame_data); end
      checks++; if (bus2.cmos_frame_href !== 1'b0) begin errors++; $display("FAIL rst_mid_href: got %b want 0", bus2.cmos_frame_href); end
      checks++; if (bus2.frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", bus2.frame_cnt); end
      cyc(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      clr();
      repeat (3) begin vs_start(); line(4, 8'h80); end
      checks++; if (nflag2 + nval2 + nval3 !== 0) begin errors++; $display("FAIL resettle_activity: got %0d want 0", nflag2 + nval2 + nval3); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b0) begin errors++; $display("FAIL resettle_fs_flag: got %b want 0", bus2.frame_val_flag); end
      cyc(1'b1, 1'b0, 8'h00);
      checks++; if (bus2.frame_val_flag !== 1'b1) begin errors++; $display("FAIL resettle_enter: got %b want 1", bus2.frame_val_flag); end
      cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
      clr();
      line(2, 8'h5A);
      checks++; if (nval2 !== 1 || bus2.cmos_frame_data !== 16'h5A5B) begin errors++; $display("FAIL resettle_pixel: got %0d/%h want 1/5a5b", nval2, bus2.cmos_frame_data); end
   endtask

   initial begin
      test_reset();
      test_settle();
      test_pack2();
      test_partial();
      test_continuous();
      test_cap_drop();
      test_single_shot();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
